// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the FIFO readout arbiter: FSM encoding and the
// legal ranges for the source count and burst length.
package fifo_read_arbiter_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } arb_state_e;

   localparam int NUM_SRC_MIN   = 2;
   localparam int NUM_SRC_MAX   = 8;
   localparam int MAX_BURST_MIN = 1;
   localparam int MAX_BURST_MAX = 255;

   function automatic bit params_ok(input int num_src, input int max_burst);
      return (num_src >= NUM_SRC_MIN) && (num_src <= NUM_SRC_MAX) &&
             (max_burst >= MAX_BURST_MIN) && (max_burst <= MAX_BURST_MAX);
   endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Source-FIFO / sink bundle of the readout arbiter. The arbiter side is
// the slave modport; the FIFOs and the sink writer sit on the master side.
interface fifo_read_arbiter_if #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 32
);
   // Handshake: SINK_EMPTY low means SINK_DATA is valid this cycle; a word is
   // transferred on every cycle where SINK_READ is high and SINK_EMPTY is low,
   // and the same cycle SRC_READ pops exactly that word from the granted FIFO.
   logic [NUM_SRC-1:0]            SRC_ENABLE;
   logic [NUM_SRC-1:0]            SRC_EMPTY;
   logic [NUM_SRC*DATA_WIDTH-1:0] SRC_DATA;
   logic [NUM_SRC-1:0]            SRC_READ;
   logic                          SINK_READ;
   logic                          SINK_EMPTY;
   logic [DATA_WIDTH-1:0]         SINK_DATA;
   logic [NUM_SRC-1:0]            GRANT;
   logic                          READ_ERROR;

   modport master (
      output SRC_ENABLE, SRC_EMPTY, SRC_DATA, SINK_READ,
      input  SRC_READ, SINK_EMPTY, SINK_DATA, GRANT, READ_ERROR
   );

   modport slave (
      input  SRC_ENABLE, SRC_EMPTY, SRC_DATA, SINK_READ,
      output SRC_READ, SINK_EMPTY, SINK_DATA, GRANT, READ_ERROR
   );
endinterface

// File: rtl/fifo_read_arbiter_rr_priority_pick.sv
// Rotating-priority picker: first set bit of elig strictly after last,
// wrapping, with last itself considered only after every other index.
module rr_priority_pick #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  elig,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] idx,
   output logic          found
);

   logic [IW-1:0] pos;

   // Walk from the farthest candidate to the nearest so the nearest wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = N; k >= 1; k--) begin
         pos = IW'((int'(last) + k) % N);
         if (elig[pos]) begin
            idx   = pos;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Burst-limited round-robin arbiter that drains several source FIFOs into
// one sink, handing over between sources without idle cycles.
module fifo_read_arbiter
   import fifo_read_arbiter_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16
) (
   input  logic                BUS_CLK,
   input  logic                BUS_RST_B,
   fifo_read_arbiter_if.slave  bus,
   output arb_state_e          dbg_state
);

   localparam int IW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int BC_W = $clog2(MAX_BURST + 1);

   if (!params_ok(NUM_SRC, MAX_BURST)) begin : g_bad_params
      $error("fifo_read_arbiter: NUM_SRC or MAX_BURST out of range");
   end

   arb_state_e         state;
   logic [IW-1:0]      g;
   logic [IW-1:0]      last_q;
   logic [BC_W-1:0]    bc;
   logic [NUM_SRC-1:0] grant_q;
   logic               err_q;

   logic [NUM_SRC-1:0]    elig;
   logic                  granted;
   logic                  cur_empty;
   logic                  cur_en;
   logic                  fwd;
   logic                  burst_done;
   logic                  release_now;
   logic [IW-1:0]         pick_last;
   logic [IW-1:0]         pick_idx;
   logic                  pick_found;
   logic [DATA_WIDTH-1:0] data_mux;
   logic [NUM_SRC-1:0]    src_read;

   always_comb begin
      elig        = bus.SRC_ENABLE & ~bus.SRC_EMPTY;
      granted     = (state == ST_GRANTED);
      cur_empty   = bus.SRC_EMPTY[g];
      cur_en      = bus.SRC_ENABLE[g];
      fwd         = granted && bus.SINK_READ && !cur_empty;
      burst_done  = fwd && (bc == BC_W'(MAX_BURST - 1));
      release_now = granted && (burst_done || cur_empty || !cur_en);
      // On release the current grant becomes the new rotation origin.
      pick_last   = granted ? g : last_q;
   end

   rr_priority_pick #(.N(NUM_SRC)) u_pick (
      .elig  (elig),
      .last  (pick_last),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      data_mux = '0;
      src_read = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (granted && (IW'(i) == g)) begin
            data_mux    = bus.SRC_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            src_read[i] = fwd;
         end
      end
   end

   assign bus.SINK_DATA  = data_mux;
   assign bus.SRC_READ   = src_read;
   assign bus.SINK_EMPTY = granted ? cur_empty : 1'b1;
   assign bus.GRANT      = grant_q;
   assign bus.READ_ERROR = err_q;
   assign dbg_state      = state;

   always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
      if (!BUS_RST_B) begin
         state   <= ST_IDLE;
         g       <= '0;
         last_q  <= IW'(NUM_SRC - 1);
         bc      <= '0;
         grant_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (bus.SINK_READ && bus.SINK_EMPTY) begin
            err_q <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state   <= ST_GRANTED;
                  g       <= pick_idx;
                  bc      <= '0;
                  grant_q <= NUM_SRC'(1) << pick_idx;
               end
            end
            ST_GRANTED: begin
               if (release_now) begin
                  last_q <= g;
                  bc     <= '0;
                  if (pick_found) begin
                     g       <= pick_idx;
                     grant_q <= NUM_SRC'(1) << pick_idx;
                  end else begin
                     state   <= ST_IDLE;
                     grant_q <= '0;
                  end
               end else begin
                  bc <= bc + BC_W'(fwd);
               end
            end
            default: begin
               state   <= ST_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: table of single-edge grant vectors
// plus per-cycle trace sequences for bursts, handovers, errors and reset.
module tb_fifo_read_arbiter;
   import fifo_read_arbiter_pkg::*;

   localparam int NS = 4;
   localparam int DW = 32;
   localparam int MB = 16;

   logic       BUS_CLK   = 1'b0;
   logic       BUS_RST_B = 1'b0;
   arb_state_e dbg_state;

   fifo_read_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

   fifo_read_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .BUS_CLK   (BUS_CLK),
      .BUS_RST_B (BUS_RST_B),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   // Source FIFO models: a FIFO holds pushed-popped words; word k of source i is {i, k}.
   int pushed[NS] = '{default: 0};
   int popped[NS] = '{default: 0};

   always @(posedge BUS_CLK) begin
      for (int i = 0; i < NS; i++) begin
         if (bus.SRC_READ[i]) popped[i] <= popped[i] + 1;
      end
   end

   always_comb begin
      bus.SRC_EMPTY = '0;
      bus.SRC_DATA  = '0;
      for (int i = 0; i < NS; i++) begin
         bus.SRC_EMPTY[i]          = (pushed[i] == popped[i]);
         bus.SRC_DATA[i*DW +: DW]  = {8'(i), 24'(popped[i])};
      end
   end

   int         tests = 0;
   int         fails = 0;
   int         exp_word[NS];
   logic [7:0] exp_q[$];

   typedef struct {
      logic [3:0] en;
      logic [3:0] ne;
      logic [3:0] exp_gnt;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int oh2idx(input logic [3:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NS; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic set_words(input int i, input int n);
      pushed[i] = popped[i] + n;
   endtask

   task automatic snap_words();
      for (int i = 0; i < NS; i++) exp_word[i] = popped[i];
   endtask

   // Leaves the bench at a negedge with reset released and all FIFOs empty.
   task automatic apply_reset();
      BUS_RST_B      = 1'b0;
      bus.SINK_READ  = 1'b0;
      bus.SRC_ENABLE = '0;
      for (int i = 0; i < NS; i++) set_words(i, 0);
      repeat (2) @(posedge BUS_CLK);
      @(negedge BUS_CLK);
      check("reset_state", {bus.GRANT, bus.SRC_READ, bus.SINK_EMPTY, bus.READ_ERROR, 1'(dbg_state)},
            {4'b0000, 4'b0000, 1'b1, 1'b0, 1'(ST_IDLE)});
      check("reset_data", bus.SINK_DATA, 0);
      BUS_RST_B = 1'b1;
      snap_words();
   endtask

   task automatic push_exp(input int rd, input int gn, input int n);
      logic [3:0] r;
      logic [3:0] g;
      r = (rd < 0) ? 4'b0000 : (4'b0001 << rd);
      g = (gn < 0) ? 4'b0000 : (4'b0001 << gn);
      for (int k = 0; k < n; k++) exp_q.push_back({r, g});
   endtask

   task automatic run_exp(input string tag);
      logic [7:0] e;
      int         idx;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(posedge BUS_CLK);
         @(negedge BUS_CLK);
         check({tag, "_rd_gnt"}, {bus.SRC_READ, bus.GRANT}, e);
         idx = oh2idx(e[7:4]);
         if (idx >= 0) begin
            check({tag, "_data"}, bus.SINK_DATA, {8'(idx), 24'(exp_word[idx])});
            exp_word[idx]++;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      bus.SINK_READ  = 1'b0;
      bus.SRC_ENABLE = '0;

      vecs[0] = '{en: 4'b1111, ne: 4'b0100, exp_gnt: 4'b0100};
      vecs[1] = '{en: 4'b1111, ne: 4'b1111, exp_gnt: 4'b0001};
      vecs[2] = '{en: 4'b1110, ne: 4'b1111, exp_gnt: 4'b0010};
      vecs[3] = '{en: 4'b1111, ne: 4'b0000, exp_gnt: 4'b0000};
      vecs[4] = '{en: 4'b0111, ne: 4'b1000, exp_gnt: 4'b0000};
      vecs[5] = '{en: 4'b1000, ne: 4'b1001, exp_gnt: 4'b1000};
      vecs[6] = '{en: 4'b1100, ne: 4'b0110, exp_gnt: 4'b0100};

      // First grant out of reset: rotation starts at source 0.
      for (int v = 0; v < 7; v++) begin
         apply_reset();
         for (int i = 0; i < NS; i++) if (vecs[v].ne[i]) set_words(i, 5);
         bus.SRC_ENABLE = vecs[v].en;
         @(posedge BUS_CLK);
         @(negedge BUS_CLK);
         check("vec_grant", bus.GRANT, vecs[v].exp_gnt);
         check("vec_sink_empty", bus.SINK_EMPTY, (vecs[v].exp_gnt == 4'b0000));
         check("vec_src_read", bus.SRC_READ, 0);
         idx = oh2idx(vecs[v].exp_gnt);
         check("vec_data", bus.SINK_DATA, (idx < 0) ? 32'd0 : {8'(idx), 24'(exp_word[idx])});
      end

      // Three words in source 2, sink always reading.
      apply_reset();
      set_words(2, 3);
      bus.SRC_ENABLE = 4'b1111;
      bus.SINK_READ  = 1'b1;
      push_exp(2, 2, 3);
      push_exp(-1, 2, 1);
      push_exp(-1, -1, 2);
      run_exp("three_words");
      check("three_words_idle", {bus.SINK_EMPTY, 1'(dbg_state)}, {1'b1, 1'(ST_IDLE)});

      // All sources full: 16-word bursts 0,1,2,3,0 with no gap.
      apply_reset();
      for (int i = 0; i < NS; i++) set_words(i, 100);
      bus.SRC_ENABLE = 4'b1111;
      bus.SINK_READ  = 1'b1;
      push_exp(0, 0, MB);
      push_exp(1, 1, MB);
      push_exp(2, 2, MB);
      push_exp(3, 3, MB);
      push_exp(0, 0, MB);
      run_exp("full_rr");

      // Single source with 40 words: 16,16,8 back to back.
      apply_reset();
      set_words(1, 40);
      bus.SRC_ENABLE = 4'b1111;
      bus.SINK_READ  = 1'b1;
      push_exp(1, 1, 40);
      push_exp(-1, 1, 1);
      push_exp(-1, -1, 2);
      run_exp("single_src");

      // Disable source 0 after its fifth word.
      apply_reset();
      for (int i = 0; i < NS; i++) set_words(i, 50);
      bus.SRC_ENABLE = 4'b1111;
      bus.SINK_READ  = 1'b1;
      push_exp(0, 0, 5);
      run_exp("disable_pre");
      bus.SRC_ENABLE = 4'b1110;
      push_exp(1, 1, MB);
      push_exp(2, 2, MB);
      push_exp(3, 3, MB);
      push_exp(1, 1, 6);
      run_exp("disable_post");

      // Read while idle sets the sticky error flag.
      apply_reset();
      bus.SINK_READ = 1'b1;
      @(posedge BUS_CLK);
      @(negedge BUS_CLK);
      check("err_set", {bus.READ_ERROR, bus.SRC_READ}, {1'b1, 4'b0000});
      bus.SINK_READ = 1'b0;
      repeat (3) @(posedge BUS_CLK);
      @(negedge BUS_CLK);
      check("err_held", bus.READ_ERROR, 1'b1);
      #2 BUS_RST_B = 1'b0;
      #1 check("err_cleared", bus.READ_ERROR, 1'b0);

      // Asynchronous reset in the middle of source 1's burst.
      apply_reset();
      for (int i = 0; i < NS; i++) set_words(i, 100);
      bus.SRC_ENABLE = 4'b1111;
      bus.SINK_READ  = 1'b1;
      push_exp(0, 0, MB);
      push_exp(1, 1, 4);
      run_exp("rst_pre");
      #2 BUS_RST_B = 1'b0;
      #1 check("rst_async", {bus.SRC_READ, bus.GRANT, bus.SINK_EMPTY}, {4'b0000, 4'b0000, 1'b1});
      apply_reset();
      for (int i = 0; i < NS; i++) set_words(i, 100);
      bus.SRC_ENABLE = 4'b1111;
      bus.SINK_READ  = 1'b1;
      push_exp(0, 0, 3);
      run_exp("rst_post");

      bus.SINK_READ = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_read_arbiter.md
FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4; number of source FIFOs, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 32; word width of every source and of the sink.
REQ-003 Parameter MAX_BURST, default 16; maximum consecutive words taken from one source per grant, range 1..255.
REQ-004 BUS_CLK  in  1  single clock for all logic.
REQ-005 BUS_RST_B  in  1  reset, asynchronous, active-low.
REQ-006 SRC_ENABLE  in  NUM_SRC  per-source enable mask; disabled sources are never granted.
REQ-007 SRC_EMPTY  in  NUM_SRC  per-source FIFO empty flags.
REQ-008 SRC_DATA  in  NUM_SRC*DATA_WIDTH  source words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SRC_READ  out  NUM_SRC  per-source read strobe; at most one bit high per cycle.
REQ-010 SINK_READ  in  1  read strobe from the downstream SRAM FIFO writer.
REQ-011 SINK_EMPTY  out  1  high when no word is presentable to the sink.
REQ-012 SINK_DATA  out  DATA_WIDTH  word of the granted source.
REQ-013 GRANT  out  NUM_SRC  one-hot registered grant; all zero when idle.
REQ-014 READ_ERROR  out  1  sticky flag: SINK_READ seen while SINK_EMPTY high.

Function
REQ-015 The block SHALL have two states, IDLE and GRANTED, with a registered grant index g and burst counter bc of width clog2(MAX_BURST+1).
REQ-016 Eligible(i) SHALL be SRC_ENABLE[i] and not SRC_EMPTY[i].
REQ-017 In IDLE, if any source is eligible, the block SHALL select the first eligible index strictly after the last-granted index (wrapping at NUM_SRC), load g, clear bc and enter GRANTED at the next edge.
REQ-018 SINK_EMPTY SHALL be 1 in IDLE and SRC_EMPTY[g] in GRANTED; SINK_DATA SHALL be SRC_DATA of g in GRANTED and 0 in IDLE (combinational mux, zero latency).
REQ-019 SRC_READ[g] SHALL equal SINK_READ and GRANTED and not SRC_EMPTY[g]; all other bits SHALL be 0.
REQ-020 Each forwarded read SHALL increment bc.
REQ-021 Release SHALL occur at the edge where: (a) a forwarded read brings bc to MAX_BURST; or (b) SRC_EMPTY[g] is high with no forwarded read; or (c) SRC_ENABLE[g] is low. A read forwarded in the releasing cycle SHALL complete.
REQ-022 On release, the last-granted index SHALL become g. If another source, or g itself, is eligible under REQ-017 ordering with g excluded until all others have been tried, the block SHALL hand over directly to GRANTED with the new index, so there is no idle cycle. Otherwise it SHALL enter IDLE.
REQ-023 Grant index SHALL change only at a clock edge, never within a cycle; the word presented on SINK_DATA SHALL stay stable until it is read or released.
REQ-024 A source becoming non-empty in the same cycle as a release SHALL be considered for that handover.
REQ-025 READ_ERROR SHALL set when SINK_READ and SINK_EMPTY are both high, and SHALL clear only on reset.
REQ-026 With a single eligible source, the block SHALL re-grant that same source after each MAX_BURST burst without an idle cycle.

Reset
REQ-027 When BUS_RST_B is low, the block SHALL immediately force: state IDLE, g=0, bc=0, last-granted=NUM_SRC-1 (source 0 first), GRANT=0, SRC_READ=0, SINK_EMPTY=1, READ_ERROR=0.
REQ-028 Reset asserted mid-burst SHALL drop the grant with no further SRC_READ; reads after deassertion SHALL restart per REQ-017.

Structure
REQ-029 The state encoding and the MAX_BURST/NUM_SRC range limits SHALL reside in a shared include/package used by the readout blocks.
REQ-030 The rotate-priority selection SHALL be a combinational sub-module rr_priority_pick, taking the eligible vector and last index and returning the next index plus a found flag.

Verification
REQ-031 Reset, then make source 2 non-empty with 3 words and hold SINK_READ high -> GRANT=0100 one cycle later, exactly 3 SRC_READ[2] pulses, then IDLE with SINK_EMPTY=1.
REQ-032 All 4 sources full, MAX_BURST=16, SINK_READ continuous -> order 0,1,2,3,0, 16 words each, no gap cycles at handovers.
REQ-033 Source 1 only, 40 words, MAX_BURST=16 -> bursts of 16,16,8 with continuous SRC_READ[1] and no idle cycle.
REQ-034 Deassert SRC_ENABLE[0] mid-burst after 5 words -> grant moves to the next eligible source at the next edge; source 0 not granted while disabled.
REQ-035 SINK_READ pulse while idle -> READ_ERROR=1, no SRC_READ, flag held until BUS_RST_B low.
REQ-036 BUS_RST_B pulled low asynchronously mid-burst -> SRC_READ=0 and GRANT=0 before the next edge; after release, source 0 is granted first.
